// File: rtl/seq_det_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_det_arbiter_if
// Brief    : Requester/detector bus of the shared sequence-detector arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_det_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 8
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] len;
  logic [NREQ-1:0]       bit_in;
  logic                  det_out;
  logic [NREQ-1:0]       grant;
  logic                  shift_en;
  logic                  det_in;
  logic                  det_clr;
  logic                  busy;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  logic [LEN_W-1:0]      done_cnt;

  modport master (
    output req, len, bit_in, det_out,
    input  grant, shift_en, det_in, det_clr, busy, done, done_id, done_cnt
  );

  modport slave (
    input  req, len, bit_in, det_out,
    output grant, shift_en, det_in, det_clr, busy, done, done_id, done_cnt
  );
endinterface
`default_nettype wire

// File: rtl/seq_det_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_det_arbiter
// Brief    : Round-robin sharing of one serial sequence detector; streams a
//            granted frame, counts latency-aligned hits and reports them.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_arbiter #(
  parameter int NREQ    = 4,
  parameter int LEN_W   = 8,
  parameter int DET_LAT = 2
) (
  input  wire logic        CLK,
  input  wire logic        RST_N,
  seq_det_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);
  localparam logic [NREQ-1:0]  c_one   = NREQ'(1);
  // The drain phase reuses the length counter, so DET_LAT must fit in LEN_W.
  localparam logic [LEN_W-1:0] c_drain = LEN_W'(DET_LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_grant;
  logic [ID_W-1:0]   r_gnt_idx, r_ptr, r_done_id, w_pick;
  logic [LEN_W-1:0]  r_rem, r_cnt, r_done_cnt, w_cnt_nxt;
  logic [DET_LAT-1:0] r_dly, w_dly_nxt;
  logic              w_found, w_shift_en, w_det_clr, w_busy, w_done, w_count_en;
  logic [LEN_W-1:0]  w_len_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign w_len_arr[gi] = bus.len[gi*LEN_W +: LEN_W];
  end

  if (DET_LAT == 1) begin : g_dly_one
    assign w_dly_nxt = w_shift_en;
  end else begin : g_dly_multi
    assign w_dly_nxt = {r_dly[DET_LAT-2:0], w_shift_en};
  end

  assign w_count_en = r_dly[DET_LAT-1];
  assign w_cnt_nxt  = (r_state == S_CLEAR) ? '0
                    : r_cnt + LEN_W'(w_count_en & bus.det_out);

  always_comb begin : p_pick
    logic [ID_W-1:0] cand;
    w_found = 1'b0;
    w_pick  = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[cand]) begin
        w_found = 1'b1;
        w_pick  = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_det_clr   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_CLEAR;
      S_CLEAR: begin
        w_det_clr   = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = (r_rem == '0) ? S_REPORT : S_STREAM;
      end
      S_STREAM: begin
        w_shift_en = 1'b1;
        w_busy     = 1'b1;
        if (r_rem == LEN_W'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (r_rem == LEN_W'(1)) w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_grant    <= '0;
      r_gnt_idx  <= '0;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_dly      <= '0;
      r_done_id  <= '0;
      r_done_cnt <= '0;
    end else begin
      r_dly <= w_dly_nxt;
      r_cnt <= w_cnt_nxt;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_grant   <= c_one << w_pick;
          r_gnt_idx <= w_pick;
          r_rem     <= w_len_arr[w_pick];
        end
        // Last stream cycle reloads the counter with the drain length.
        S_STREAM: r_rem <= (r_rem == LEN_W'(1)) ? c_drain : r_rem - 1'b1;
        S_DRAIN:  r_rem <= r_rem - 1'b1;
        S_REPORT: begin
          r_grant <= '0;
          r_ptr   <= (r_gnt_idx == ID_W'(NREQ-1)) ? '0 : r_gnt_idx + 1'b1;
        end
        default: ;
      endcase
      if (w_state_nxt == S_REPORT && r_state != S_REPORT) begin
        r_done_id  <= r_gnt_idx;
        r_done_cnt <= w_cnt_nxt;
      end
    end
  end

  assign bus.grant    = r_grant;
  assign bus.shift_en = w_shift_en;
  assign bus.det_in   = w_shift_en & bus.bit_in[r_gnt_idx];
  assign bus.det_clr  = w_det_clr;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.done_id  = r_done_id;
  assign bus.done_cnt = r_done_cnt;
endmodule
`default_nettype wire

// File: tb/tb_seq_det_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_arbiter
// Brief    : Randomized bench with a frame-schedule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_arbiter;
  localparam int NREQ = 4, LEN_W = 8, DET_LAT = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  seq_det_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();
  seq_det_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .DET_LAT(DET_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.slave)
  );

  int n_tests = 0, n_fail = 0;

  // stimulus knobs
  logic [NREQ-1:0] s_req;
  int  s_len [NREQ];
  bit  rand_mode;
  int  det_mode;   // 0 random, 1 held high

  // reference model: a frame is a schedule of phases counted from the grant
  bit m_act;
  int m_p, m_len, m_id, m_cnt, m_ptr, m_last_id, m_last_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_p = 0; m_len = 0; m_id = 0; m_cnt = 0;
    m_ptr = 0; m_last_id = 0; m_last_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_grant"},    32'(bus.grant),    32'd0);
    check_val({tag, "_shift_en"}, 32'(bus.shift_en), 32'd0);
    check_val({tag, "_det_clr"},  32'(bus.det_clr),  32'd0);
    check_val({tag, "_busy"},     32'(bus.busy),     32'd0);
    check_val({tag, "_done"},     32'(bus.done),     32'd0);
    check_val({tag, "_done_id"},  32'(bus.done_id),  32'd0);
    check_val({tag, "_done_cnt"}, 32'(bus.done_cnt), 32'd0);
  endtask

  task automatic drive();
    if (rand_mode) begin
      s_req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        s_len[i] = ($urandom_range(0, 199) == 0) ? int'($urandom_range(200, 255))
                                                 : int'($urandom_range(0, 7));
    end
    bus.req = s_req;
    for (int i = 0; i < NREQ; i++) bus.len[i*LEN_W +: LEN_W] = LEN_W'(s_len[i]);
    bus.bit_in  = NREQ'($urandom);
    bus.det_out = (det_mode == 1) ? 1'b1 : 1'($urandom);
  endtask

  task automatic model_cycle();
    int  rep_p;
    bit  e_sh, e_done;
    logic [31:0] e_grant;
    rep_p   = (m_len == 0) ? 2 : m_len + DET_LAT + 2;
    e_grant = m_act ? (32'd1 << m_id) : 32'd0;
    e_sh    = m_act && m_p >= 2 && m_p <= m_len + 1;
    e_done  = m_act && m_p == rep_p;
    if (e_done) begin
      m_last_id  = m_id;
      m_last_cnt = m_cnt;
    end
    check_val("grant",    32'(bus.grant),    e_grant);
    check_val("busy",     32'(bus.busy),     32'(m_act));
    check_val("det_clr",  32'(bus.det_clr),  32'(m_act && m_p == 1));
    check_val("shift_en", 32'(bus.shift_en), 32'(e_sh));
    check_val("det_in",   32'(bus.det_in),   32'(e_sh && bus.bit_in[m_id]));
    check_val("done",     32'(bus.done),     32'(e_done));
    check_val("done_id",  32'(bus.done_id),  32'(m_last_id));
    check_val("done_cnt", 32'(bus.done_cnt), 32'(m_last_cnt));
    if (m_act) begin
      if (m_p >= 2 + DET_LAT && m_p <= m_len + 1 + DET_LAT && bus.det_out) m_cnt++;
      if (m_p == rep_p) begin
        m_act = 1'b0;
        m_ptr = (m_id + 1) % NREQ;
      end else m_p++;
    end else if (bus.req != '0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (bus.req[(m_ptr + k) % NREQ]) m_id = (m_ptr + k) % NREQ;
      m_len = int'(bus.len[m_id*LEN_W +: LEN_W]);
      m_act = 1'b1;
      m_p   = 1;
      m_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1 drive();
    #1 model_cycle();
  endtask

  task automatic step_until_phase(input int phase, input string tag);
    bit hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      step();
      hit = m_act && m_p == phase;
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    rand_mode = 1'b0; det_mode = 0; s_req = '0;
    for (int i = 0; i < NREQ; i++) s_len[i] = 0;
    bus.req = '0; bus.len = '0; bus.bit_in = '0; bus.det_out = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 check_all_zero("reset");
    @(negedge CLK) RST_N = 1'b1;

    // round robin from ptr 0: 0001, 0010, 1000, 0001
    s_req = 4'b1011;
    for (int i = 0; i < NREQ; i++) s_len[i] = 1;
    repeat (30) step();

    // single request, len 5
    s_req = 4'b0100; s_len[2] = 5;
    repeat (24) step();

    // zero-length frames
    s_req = 4'b0010; s_len[1] = 0;
    repeat (12) step();

    // window alignment with det_out held high
    det_mode = 1; s_req = 4'b0001;
    for (int i = 0; i < NREQ; i++) s_len[i] = 3;
    repeat (20) step();
    det_mode = 0;

    // request dropped mid-stream
    s_req = 4'b0001; s_len[0] = 6;
    step_until_phase(3, "reach_drop_point");
    s_req = '0;
    repeat (15) step();

    // asynchronous reset mid-stream
    s_req = 4'b0100;
    for (int i = 0; i < NREQ; i++) s_len[i] = 10;
    step_until_phase(4, "reach_reset_point");
    @(posedge CLK);
    #3 RST_N = 1'b0;
    s_req = '0; bus.req = '0;
    #1 check_all_zero("midreset");
    check_val("midreset_det_in", 32'(bus.det_in), 32'd0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    s_req = 4'b1111;
    repeat (12) step();

    // maximum length frame
    s_req = 4'b0010; s_len[1] = 255;
    repeat (275) step();

    // randomized traffic
    rand_mode = 1'b1;
    repeat (3000) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
